conv_result_collector: RTL and testbench

- Receiving end of the computing_core output stream: captures data_out_0 results as the core produces them and stores them in an internal result buffer.
- Tracks frame completion from the core's done flag.
- Presents a registered read port so the host/readback logic drains results in order.
- Mirror of the input-side feeder that streams kernel and data words into the core.

---
 rtl/conv_result_collector.sv | 110 +++++++++++
 tb/tb_conv_result_collector.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_result_collector.sv
// Result buffer on the output side of computing_core: collects data_out_0 words per frame
// and drains them in order through a registered read port. Define RESULT_CHECKSUM_EN for a running checksum.
module conv_result_collector #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    input  logic              core_done,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              frame_done,
    output logic              busy,
    output logic [DATA_W-1:0] checksum
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;

    logic [1:0]        state;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic rd_fire;
    logic wr_attempt;
    logic wr_fire;
    logic wr_drop;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign busy  = (state == COLLECT);

    // A read in the same cycle frees a slot, so a write into a full buffer still lands.
    assign rd_fire    = rd_en && !empty && !start;
    assign wr_attempt = res_valid && (state == COLLECT) && !start;
    assign wr_fire    = wr_attempt && (!full || rd_fire);
    assign wr_drop    = wr_attempt && full && !rd_fire;

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr] <= res_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            overflow   <= 1'b0;
            frame_done <= 1'b0;
        end else if (start) begin
            state      <= COLLECT;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            rd_valid   <= 1'b0;
            overflow   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr];
            end
            rd_valid <= rd_fire;
            count    <= count + CNT_W'(wr_fire) - CNT_W'(rd_fire);
            if (wr_drop) begin
                overflow <= 1'b1;
            end
            if (state == COLLECT && core_done) begin
                state      <= DONE;
                frame_done <= 1'b1;
            end
        end
    end

`ifdef RESULT_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            checksum <= '0;
        end else if (start) begin
            checksum <= '0;
        end else if (wr_fire) begin
            checksum <= checksum + res_data;
        end
    end
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_conv_result_collector.sv
// Directed bench for conv_result_collector: a vector table for the basic frame plus
// hand-written sequences for overflow, full read/write, done coincidence, async reset and start priority.
module tb_conv_result_collector;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              res_valid = 1'b0;
    logic [DATA_W-1:0] res_data = '0;
    logic              core_done = 1'b0;
    logic              rd_en = 1'b0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              overflow;
    logic              frame_done;
    logic              busy;
    logic [DATA_W-1:0] checksum;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rd_data;
        logic        rd_valid;
        logic [31:0] count;
        logic        full;
        logic        empty;
        logic        overflow;
        logic        frame_done;
        logic        busy;
        logic [31:0] sum;
    } expect_t;

    typedef struct {
        logic        start;
        logic        res_valid;
        logic [31:0] res_data;
        logic        core_done;
        logic        rd_en;
        expect_t     exp;
    } vector_t;

    conv_result_collector #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .core_done  (core_done),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow),
        .frame_done (frame_done),
        .busy       (busy),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    function automatic expect_t mk(input logic [31:0] rdd, input logic rdv, input logic [31:0] cnt,
                                   input logic ovf, input logic fd, input logic bsy, input logic [31:0] sum);
        expect_t e;
        e.rd_data    = rdd;
        e.rd_valid   = rdv;
        e.count      = cnt;
        e.full       = (cnt == 32'(DEPTH));
        e.empty      = (cnt == 32'd0);
        e.overflow   = ovf;
        e.frame_done = fd;
        e.busy       = bsy;
        e.sum        = sum;
        return e;
    endfunction

    function automatic logic [31:0] sumExp(input logic [31:0] s);
`ifdef RESULT_CHECKSUM_EN
        return s;
`else
        return 32'd0 & s;
`endif
    endfunction

    task automatic cmp(input string tag, input string field, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s.%s: got %0d, expected %0d", tag, field, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input expect_t e);
        cmp(tag, "rd_data",    rd_data,           e.rd_data);
        cmp(tag, "rd_valid",   32'(rd_valid),     32'(e.rd_valid));
        cmp(tag, "count",      32'(count),        e.count);
        cmp(tag, "full",       32'(full),         32'(e.full));
        cmp(tag, "empty",      32'(empty),        32'(e.empty));
        cmp(tag, "overflow",   32'(overflow),     32'(e.overflow));
        cmp(tag, "frame_done", 32'(frame_done),   32'(e.frame_done));
        cmp(tag, "busy",       32'(busy),         32'(e.busy));
        cmp(tag, "checksum",   checksum,          sumExp(e.sum));
    endtask

    // Drives one cycle of inputs at the falling edge and returns just after the next rising edge.
    task automatic applyStimulus(input logic s, input logic rv, input logic [31:0] d,
                                 input logic cd, input logic re);
        @(negedge clk);
        start     = s;
        res_valid = rv;
        res_data  = d;
        core_done = cd;
        rd_en     = re;
        @(posedge clk);
        #1;
    endtask

    vector_t vec[9];

    initial begin
        // Basic frame: 10, 20, 30, done, then drain plus one read on empty.
        vec[0] = '{1, 0,  0, 0, 0, mk( 0, 0, 0, 0, 0, 1,  0)};
        vec[1] = '{0, 1, 10, 0, 0, mk( 0, 0, 1, 0, 0, 1, 10)};
        vec[2] = '{0, 1, 20, 0, 0, mk( 0, 0, 2, 0, 0, 1, 30)};
        vec[3] = '{0, 1, 30, 0, 0, mk( 0, 0, 3, 0, 0, 1, 60)};
        vec[4] = '{0, 0,  0, 1, 0, mk( 0, 0, 3, 0, 1, 0, 60)};
        vec[5] = '{0, 0,  0, 0, 1, mk(10, 1, 2, 0, 1, 0, 60)};
        vec[6] = '{0, 0,  0, 0, 1, mk(20, 1, 1, 0, 1, 0, 60)};
        vec[7] = '{0, 0,  0, 0, 1, mk(30, 1, 0, 0, 1, 0, 60)};
        vec[8] = '{0, 0,  0, 0, 1, mk(30, 0, 0, 0, 1, 0, 60)};

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", mk(0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vec[i].start, vec[i].res_valid, vec[i].res_data, vec[i].core_done, vec[i].rd_en);
            checkOutput($sformatf("vec%0d", i), vec[i].exp);
        end

        // Overflow: 18 beats into a 16-deep buffer.
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("ovf_start", mk(30, 0, 0, 0, 0, 1, 0));
        for (int i = 0; i < 18; i++) begin
            int n;
            n = (i < 16) ? i + 1 : 16;
            applyStimulus(0, 1, 32'(i), 0, 0);
            checkOutput($sformatf("ovf_beat%0d", i),
                        mk(30, 0, 32'(n), (i >= 16), 0, 1, 32'(n * (n - 1) / 2)));
        end

        // Full buffer: simultaneous read and write keeps count at 16.
        applyStimulus(0, 1, 99, 0, 1);
        checkOutput("full_rw", mk(0, 1, 16, 1, 0, 1, 219));
        for (int k = 1; k < 16; k++) begin
            applyStimulus(0, 0, 0, 0, 1);
            checkOutput($sformatf("drain%0d", k), mk(32'(k), 1, 32'(16 - k), 1, 0, 1, 219));
        end
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("drain_last", mk(99, 1, 0, 1, 0, 1, 219));

        // Result coincident with core_done is kept; later results are ignored.
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("cd_start", mk(99, 0, 0, 0, 0, 1, 0));
        applyStimulus(0, 1, 7, 1, 0);
        checkOutput("cd_with_data", mk(99, 0, 1, 0, 1, 0, 7));
        applyStimulus(0, 1, 8, 0, 0);
        checkOutput("cd_after", mk(99, 0, 1, 0, 1, 0, 7));
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("cd_read", mk(7, 1, 0, 0, 1, 0, 7));

        // Asynchronous reset mid-frame after five writes.
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(0, 1, 32'(i), 0, 0);
        end
        checkOutput("pre_reset", mk(7, 0, 5, 0, 0, 1, 15));
        @(negedge clk);
        res_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_reset", mk(0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("post_reset_rd", mk(0, 0, 0, 0, 0, 0, 0));

        // Start outranks a coincident result and a coincident read.
        applyStimulus(1, 1, 55, 0, 0);
        checkOutput("start_rv", mk(0, 0, 0, 0, 0, 1, 0));
        applyStimulus(0, 1, 66, 0, 0);
        checkOutput("after_start_rv", mk(0, 0, 1, 0, 0, 1, 66));
        applyStimulus(1, 0, 0, 0, 1);
        checkOutput("start_rd", mk(0, 0, 0, 0, 0, 1, 0));
        applyStimulus(0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
